// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes written at bus speed are queued in a
// circular FIFO and shifted out LSB first on tx_o by a baud-counted FSM.
module uart_tx_buf #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          we_i,
    input  logic [7:0]                    wdata_i,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          idle_o,
    output logic                          ovf_o,
    input  logic                          ovf_clr_i,
    output logic                          tx_o,
    output logic [1:0]                    state_o
);

    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             ovf_q;
    logic             wr_en;
    logic             pop;
    logic             full;

    // Transmit FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_last;
    logic             fifo_nonempty;

    assign full          = (count_q == LVL_FULL);
    assign fifo_nonempty = (count_q != '0);
    // A write into a full FIFO is dropped even if the FSM pops in the same cycle.
    assign wr_en         = we_i && !full;
    assign baud_last     = (baud_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (we_i && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Next bit comes from the position that becomes the new LSB.
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign full_o  = full;
    assign level_o = count_q;
    assign idle_o  = (state_q == S_IDLE) && !fifo_nonempty;
    assign ovf_o   = ovf_q;
    assign tx_o    = tx_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed + randomized bench for uart_tx_buf: an independent serial receiver
// decodes tx_o and its bytes are scored against a queue of accepted writes.
module tb_uart_tx_buf;

    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       we_i;
    logic [7:0] wdata_i;
    logic       full_o;
    logic [3:0] level_o;
    logic       idle_o;
    logic       ovf_o;
    logic       ovf_clr_i;
    logic       tx_o;
    logic [1:0] state_o;

    uart_tx_buf #(
        .CLK_FREQ  (50_000_000),
        .BAUD      (5_000_000),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .full_o   (full_o),
        .level_o  (level_o),
        .idle_o   (idle_o),
        .ovf_o    (ovf_o),
        .ovf_clr_i(ovf_clr_i),
        .tx_o     (tx_o),
        .state_o  (state_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_events = 0;
    always @(negedge rst_ni) rst_events <= rst_events + 1;

    int   tx_toggles = 0;
    logic tx_prev = 1'b1;
    always @(negedge clk) begin
        if (tx_o !== tx_prev) tx_toggles <= tx_toggles + 1;
        tx_prev <= tx_o;
    end

    // serial receiver: samples mid-bit, records {frame_ok, byte} and start cycle
    logic [8:0] got_q[$];
    int         starts_q[$];

    initial begin : rx_mon
        logic [9:0] bits;
        int         t;
        int         r0;
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1 && tx_o === 1'b0) begin
                t  = cyc;
                r0 = rst_events;
                bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < ((b == 0) ? CPB / 2 : CPB); k++) @(negedge clk);
                    bits[b] = tx_o;
                end
                if (rst_events == r0 && rst_ni === 1'b1) begin
                    got_q.push_back({(bits[0] == 1'b0 && bits[9] == 1'b1), bits[8:1]});
                    starts_q.push_back(t);
                end
            end
        end
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int rx_rd    = 0;
    int last_wr_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cycle(input logic [7:0] b, input logic clr);
        we_i        = 1'b1;
        wdata_i     = b;
        ovf_clr_i   = clr;
        last_wr_cyc = cyc;
        @(posedge clk);
        #1;
        we_i      = 1'b0;
        ovf_clr_i = 1'b0;
    endtask

    task automatic clear_ovf();
        ovf_clr_i = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = (idle_o === 1'b1);
        end
        check({tag, "_idle_wait"}, 32'(seen), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        logic [8:0] g;
        while (rx_rd < got_q.size()) begin
            g = got_q[rx_rd];
            rx_rd++;
            check({tag, "_framing"}, 32'(g[8]), 32'd1);
            check({tag, "_unexpected_byte"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check({tag, "_rx_byte"}, 32'(g[7:0]), 32'(exp_q.pop_front()));
        end
        check({tag, "_pending_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        int s0;
        int k;
        int g0;
        int t0;
        logic [7:0] b;

        rst_ni = 1'b0; we_i = 1'b0; wdata_i = 8'h00; ovf_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // single byte 0xA5: exact latency and waveform
        wait_idle("t1");
        write_cycle(8'hA5, 1'b0);
        exp_q.push_back(8'hA5);
        @(negedge clk);                              // N+1
        check("t1_level_n1", 32'(level_o), 32'd1);
        check("t1_idle_n1", 32'(idle_o), 32'd0);
        check("t1_tx_n1", 32'(tx_o), 32'd1);
        @(negedge clk);                              // N+2
        check("t1_tx_n2", 32'(tx_o), 32'd0);
        check("t1_level_n2", 32'(level_o), 32'd0);
        repeat (9) @(negedge clk);                   // N+11
        check("t1_tx_n11", 32'(tx_o), 32'd0);
        @(negedge clk);                              // N+12, bit0 of A5
        check("t1_tx_n12", 32'(tx_o), 32'd1);
        repeat (89) @(negedge clk);                  // N+101
        check("t1_tx_n101", 32'(tx_o), 32'd1);
        check("t1_idle_n101", 32'(idle_o), 32'd0);
        @(negedge clk);                              // N+102
        check("t1_idle_n102", 32'(idle_o), 32'd1);
        check_rx("t1");

        // three consecutive writes, back-to-back frames
        wait_idle("t2");
        s0 = starts_q.size();
        write_cycle(8'h01, 1'b0);
        w0 = last_wr_cyc;
        check("t2_level_a", 32'(level_o), 32'd1);
        write_cycle(8'h02, 1'b0);
        check("t2_level_b", 32'(level_o), 32'd1);
        write_cycle(8'h03, 1'b0);
        check("t2_level_c", 32'(level_o), 32'd2);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        wait_idle("t2b");
        check("t2_frames", 32'(starts_q.size() - s0), 32'd3);
        if (starts_q.size() - s0 == 3) begin
            check("t2_start0", 32'(starts_q[s0]), 32'(w0 + 2));
            check("t2_gap01", 32'(starts_q[s0 + 1] - starts_q[s0]), 32'(FRAME));
            check("t2_gap12", 32'(starts_q[s0 + 2] - starts_q[s0 + 1]), 32'(FRAME));
        end
        check_rx("t2");

        // fill to full, overflow, clear/overflow race, write+pop while full
        wait_idle("t3");
        for (int i = 0; i < 9; i++) begin
            write_cycle(8'h10 + 8'(i), 1'b0);
            if (i == 0) w0 = last_wr_cyc;
            exp_q.push_back(8'h10 + 8'(i));
        end
        check("t3_level_full", 32'(level_o), 32'd8);
        check("t3_full", 32'(full_o), 32'd1);
        check("t3_no_ovf", 32'(ovf_o), 32'd0);
        write_cycle(8'h19, 1'b0);
        check("t3_ovf_set", 32'(ovf_o), 32'd1);
        check("t3_level_kept", 32'(level_o), 32'd8);
        write_cycle(8'h1A, 1'b1);
        check("t4_set_wins", 32'(ovf_o), 32'd1);
        clear_ovf();
        check("t4_cleared", 32'(ovf_o), 32'd0);
        while (cyc < w0 + 101) begin
            @(posedge clk);
            #1;
        end
        check("t6_pre_level", 32'(level_o), 32'd8);
        write_cycle(8'h1B, 1'b0);
        check("t6_level", 32'(level_o), 32'd7);
        check("t6_ovf", 32'(ovf_o), 32'd1);
        check("t6_not_full", 32'(full_o), 32'd0);
        clear_ovf();
        check("t6_cleared", 32'(ovf_o), 32'd0);
        wait_idle("t3b");
        check_rx("t3");

        // randomized bursts from idle
        for (int r = 0; r < 6; r++) begin
            wait_idle("rnd");
            k = $urandom_range(1, 8);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom_range(0, 255));
                write_cycle(b, 1'b0);
                exp_q.push_back(b);
            end
            check("rnd_level", 32'(level_o), 32'((k == 1) ? 1 : k - 1));
            check("rnd_ovf", 32'(ovf_o), 32'd0);
            wait_idle("rnd_b");
            check_rx("rnd");
        end

        // reset during bit 3 of a frame with 4 bytes queued
        wait_idle("t5");
        for (int i = 0; i < 5; i++) begin
            write_cycle(8'hC0 + 8'(i), 1'b0);
            if (i == 0) w0 = last_wr_cyc;
        end
        while (cyc < w0 + 47) begin
            @(posedge clk);
            #1;
        end
        check("t5_tx_bit3_low", 32'(tx_o), 32'd0);
        g0 = got_q.size();
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("t5_tx_high", 32'(tx_o), 32'd1);
        check("t5_level", 32'(level_o), 32'd0);
        check("t5_idle", 32'(idle_o), 32'd1);
        check("t5_full", 32'(full_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #1;
        t0 = tx_toggles;
        repeat (200) @(negedge clk);
        check("t5_no_toggles", 32'(tx_toggles - t0), 32'd0);
        check("t5_no_frames", 32'(got_q.size() - g0), 32'd0);
        check("t5_idle_after", 32'(idle_o), 32'd1);
        check("t5_level_after", 32'(level_o), 32'd0);
        check_rx("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
